// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// State encoding, counter widths and index-width helper.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int STALL_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first eligible index at or after start,
// wrapping modulo NREQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        eligible,
  input  logic [idx_w(NREQ)-1:0] start,
  output logic                   found,
  output logic [idx_w(NREQ)-1:0] idx
);

  localparam int IW = idx_w(NREQ);

  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(start) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && eligible[IW'(j)]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among
// NREQ requesters; holds a grant for a packet or MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DSIZE-1:0]  req_data,
  input  logic [NREQ-1:0]        req_last,
  input  logic [NREQ-1:0]        req_mask,
  output logic [NREQ-1:0]        req_ready,
  output logic [DSIZE-1:0]       wdata,
  output logic                   winc,
  input  logic                   wfull,
  output logic [idx_w(NREQ)-1:0] grant_id,
  output logic                   busy,
  output logic [STALL_W-1:0]     stall_cnt
);

  localparam int IW = idx_w(NREQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_ID  = IW'(NREQ - 1);

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   last_gnt;
  logic [IW-1:0]   start;
  logic [IW-1:0]   pick;
  logic [BW-1:0]   beat_cnt;
  logic [DSIZE-1:0] dat [NREQ];
  logic [NREQ-1:0] eligible;
  logic            found;
  logic            cur_valid;
  logic            cur_last;
  logic            accept;
  logic            rel;
  logic            load;
  logic            in_grant;

  for (genvar i = 0; i < NREQ; i++) begin : g_dat
    assign dat[i] = req_data[i*DSIZE +: DSIZE];
  end

  assign eligible = req_valid & req_mask;

  // last_gnt equals grant_id while granted, so one picker
  // serves both the idle arbitration and the release switch
  assign start = (last_gnt == LAST_ID) ? '0
               : last_gnt + IW'(1);

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .eligible (eligible),
    .start    (start),
    .found    (found),
    .idx      (pick)
  );

  assign in_grant  = (state == ST_GRANT);
  assign cur_valid = req_valid[grant_id];
  assign cur_last  = req_last[grant_id];
  assign accept    = in_grant & cur_valid & ~wfull;

  assign rel = in_grant
             & (~cur_valid
             | (accept & (cur_last
             | (beat_cnt == BEAT_MAX))));

  assign load = found & (~in_grant | rel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (found) state_nx = ST_GRANT;
      ST_GRANT: if (rel && !found) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = in_grant;
    winc      = accept;
    req_ready = '0;
    req_ready[grant_id] = accept;
    wdata     = in_grant ? dat[grant_id] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id <= '0;
      last_gnt <= LAST_ID;
      beat_cnt <= '0;
    end else begin
      if (load) begin
        grant_id <= pick;
        last_gnt <= pick;
      end
      if (load || rel)  beat_cnt <= '0;
      else if (accept)  beat_cnt <= beat_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_grant && cur_valid && wfull
                 && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed requester
// streams, expected writes queued, monitor checks each winc.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_mask;
  logic [NREQ-1:0]       req_ready;
  logic [DSIZE-1:0]      wdata;
  logic                  winc;
  logic                  wfull;
  logic [1:0]            grant_id;
  logic                  busy;
  logic [15:0]           stall_cnt;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DSIZE     (DSIZE),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_mask  (req_mask),
    .req_ready (req_ready),
    .wdata     (wdata),
    .winc      (winc),
    .wfull     (wfull),
    .grant_id  (grant_id),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  int cnt     [NREQ];
  int lim     [NREQ];
  int last_at [NREQ];

  logic [9:0] q [$];
  logic [9:0] e;

  logic            s_winc;
  logic            s_busy;
  logic [1:0]      s_gnt;
  logic [NREQ-1:0] s_rdy;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic push(input int id, input int d);
    q.push_back({2'(id), 8'(d)});
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (cnt[i] < lim[i]);
      req_data[i*DSIZE +: DSIZE] = 8'(i*16 + cnt[i]);
      req_last[i] = (cnt[i] == last_at[i]);
    end
  endtask

  // one cycle: sample mid-cycle, then advance on the edge
  task automatic tick();
    @(negedge clk);
    s_winc = winc;
    s_busy = busy;
    s_gnt  = grant_id;
    s_rdy  = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (s_rdy[i]) cnt[i]++;
    drive();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    wfull    = 1'b0;
    req_mask = '1;
    for (int i = 0; i < NREQ; i++) begin
      cnt[i]     = 0;
      lim[i]     = 0;
      last_at[i] = -1;
    end
    drive();
  endtask

  task automatic start();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && winc) begin
      chk("winc_while_full", {31'd0, wfull}, 0);
      if (q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h expected none",
                 wdata);
      end else begin
        e = q.pop_front();
        chk("wdata", {24'd0, wdata}, {24'd0, e[7:0]});
        chk("wr_gnt", {30'd0, grant_id}, {30'd0, e[9:8]});
        chk("ready_onehot", {28'd0, req_ready},
            32'(1) << e[9:8]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    wfull    = 1'b0;
    req_mask = '1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cnt[i]     = 0;
      lim[i]     = 8;
      last_at[i] = -1;
    end
    drive();
    #2;
    chk("rst_winc", {31'd0, winc}, 0);
    chk("rst_ready", {28'd0, req_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_gnt", {30'd0, grant_id}, 0);
    chk("rst_stall", {16'd0, stall_cnt}, 0);
    chk("rst_wdata", {24'd0, wdata}, 0);

    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        for (int b = 0; b < 4; b++)
          push(i, i*16 + r*4 + b);
    start();
    tick();
    chk("arb_winc", {31'd0, s_winc}, 0);
    chk("arb_busy", {31'd0, s_busy}, 0);
    chk("first_gnt", {30'd0, grant_id}, 0);
    chk("first_busy", {31'd0, busy}, 1);
    for (int k = 0; k < 32; k++) begin
      tick();
      chk("stream_winc", {31'd0, s_winc}, 1);
      chk("stream_gnt", {30'd0, s_gnt}, 32'((k / 4) % 4));
    end
    tick();
    tick();
    chk("rr_idle", {31'd0, busy}, 0);
    chk("rr_q_empty", q.size(), 0);

    do_reset();
    for (int i = 0; i < 3; i++) lim[i] = 4;
    for (int i = 0; i < 3; i++)
      for (int b = 0; b < 4; b++)
        push(i, i*16 + b);
    start();
    tick();
    for (int k = 0; k < 6; k++) tick();
    wfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_winc", {31'd0, s_winc}, 0);
      chk("stall_ready", {28'd0, s_rdy}, 0);
      chk("stall_gnt", {30'd0, s_gnt}, 1);
    end
    wfull = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("stall_cnt", {16'd0, stall_cnt}, 3);
    chk("stall_idle", {31'd0, busy}, 0);
    chk("stall_q_empty", q.size(), 0);

    do_reset();
    lim[1]     = 2;
    last_at[1] = 1;
    lim[2]     = 4;
    push(1, 16);
    push(1, 17);
    for (int b = 0; b < 4; b++) push(2, 32 + b);
    start();
    tick();
    chk("last_first_gnt", {30'd0, grant_id}, 1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("last_winc1", {31'd0, s_winc}, 1);
    end
    chk("last_switch", {30'd0, grant_id}, 2);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("last_winc2", {31'd0, s_winc}, 1);
    end
    tick();
    tick();
    chk("last_idle", {31'd0, busy}, 0);
    chk("last_q_empty", q.size(), 0);

    do_reset();
    lim[3]   = 2;
    req_mask = 4'b0111;
    start();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mask_busy", {31'd0, s_busy}, 0);
      chk("mask_winc", {31'd0, s_winc}, 0);
    end
    req_mask = 4'b1111;
    push(3, 48);
    push(3, 49);
    tick();
    chk("unmask_arb", {31'd0, s_busy}, 0);
    chk("unmask_gnt", {30'd0, grant_id}, 3);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("unmask_winc", {31'd0, s_winc}, 1);
    end
    tick();
    tick();
    chk("mask_q_empty", q.size(), 0);

    do_reset();
    for (int i = 0; i < NREQ; i++) lim[i] = 8;
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++)
        push(i, i*16 + b);
    push(2, 32);
    push(2, 33);
    start();
    tick();
    for (int k = 0; k < 10; k++) tick();
    #2;
    chk("pre_rst_winc", {31'd0, winc}, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_winc", {31'd0, winc}, 0);
    chk("mid_rst_ready", {28'd0, req_ready}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_gnt", {30'd0, grant_id}, 0);
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    for (int b = 0; b < 4; b++) push(0, b);
    start();
    tick();
    chk("post_rst_gnt", {30'd0, grant_id}, 0);
    chk("post_rst_busy", {31'd0, busy}, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_winc", {31'd0, s_winc}, 1);
    end
    rst = 1'b1;
    #1;
    chk("final_q_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
